// File: rtl/fpu_outbuf_fmac.sv
// ---------------------------------------------------------------------------
// fpu_outbuf_fmac
// Output stage behind the FMAC normalisation/rounding stage. Each accepted
// result is packed into an IEEE-754 word together with its per-operation
// exception flags and sideband tag. It is then held in a small FIFO until the
// consumer takes it. A sticky fflags register collects the flags of every
// result the consumer accepts.
//
// Optional build macro: FPU_OF_SATURATE_EN
//   defined   : overflowed results are replaced by the IEEE overflow value
//               (largest finite or Inf, depending on RM_SI and the sign)
//   undefined : the result is always the plain pack and RM_SI is unused
//
// Ports
//   Clk_CI, Rst_RI          clock, synchronous active-high reset
//   Valid_SI / Ready_SO     upstream handshake (Ready_SO = not full)
//   Mant_res_DI, Exp_res_DI, Sign_res_DI   rounded result fields
//   Exp_OF_SI, Exp_UF_SI, Flag_Inexact_SI, Flag_Invalid_SI, Inf_in_SI
//                           status from the rounding stage
//   RM_SI                   rounding mode of the operation
//   Tag_DI                  sideband tag
//   Valid_SO / Ready_SI     downstream handshake
//   Result_DO, Tag_DO, Flags_DO   head entry ({NV,DZ,OF,UF,NX})
//   Fflags_clr_SI, Fflags_DO      sticky flag clear / accumulated flags
// ---------------------------------------------------------------------------
module fpu_outbuf_fmac #(
  parameter int unsigned C_OP     = 32,
  parameter int unsigned C_EXP    = 8,
  parameter int unsigned C_MANT   = 23,
  parameter int unsigned C_TAG    = 4,
  parameter int unsigned C_DEPTH  = 2,
  parameter int unsigned C_RM     = 3,
  parameter logic [C_RM-1:0] C_RM_TRUNC    = 3'b001,
  parameter logic [C_RM-1:0] C_RM_MINUSINF = 3'b010,
  parameter logic [C_RM-1:0] C_RM_PLUSINF  = 3'b011
) (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  input  logic              Valid_SI,
  output logic              Ready_SO,
  input  logic [C_MANT-1:0] Mant_res_DI,
  input  logic [C_EXP-1:0]  Exp_res_DI,
  input  logic              Sign_res_DI,
  input  logic              Exp_OF_SI,
  input  logic              Exp_UF_SI,
  input  logic              Flag_Inexact_SI,
  input  logic              Flag_Invalid_SI,
  input  logic              Inf_in_SI,
  input  logic [C_RM-1:0]   RM_SI,
  input  logic [C_TAG-1:0]  Tag_DI,
  output logic              Valid_SO,
  input  logic              Ready_SI,
  output logic [C_OP-1:0]   Result_DO,
  output logic [C_TAG-1:0]  Tag_DO,
  output logic [4:0]        Flags_DO,
  input  logic              Fflags_clr_SI,
  output logic [4:0]        Fflags_DO
);

  localparam int unsigned PTR_W = $clog2(C_DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [4:0]       fflags_reg;

  logic [C_OP-1:0]  res_mem   [C_DEPTH];
  logic [C_TAG-1:0] tag_mem   [C_DEPTH];
  logic [4:0]       flags_mem [C_DEPTH];

  logic push, pop;
  logic flag_nv, flag_of, flag_uf, flag_nx;
  logic [4:0]      flags_next;
  logic [C_OP-1:0] res_next;

  // Handshake decisions depend on registered state only, so Ready_SO never
  // combinationally follows Ready_SI.
  assign Ready_SO = (count_reg != C_DEPTH[PTR_W:0]);
  assign Valid_SO = (count_reg != '0);
  assign push     = Valid_SI & Ready_SO;
  assign pop      = Valid_SO & Ready_SI;

  // Per-operation flags. An invalid operation suppresses everything else.
  // Overflow is not signalled when an operand was already infinite.
  assign flag_nv    = Flag_Invalid_SI;
  assign flag_of    = Exp_OF_SI & ~Flag_Invalid_SI & ~Inf_in_SI;
  assign flag_uf    = Exp_UF_SI & Flag_Inexact_SI & ~Flag_Invalid_SI;
  assign flag_nx    = (Flag_Inexact_SI | flag_of) & ~Flag_Invalid_SI;
  assign flags_next = {flag_nv, 1'b0, flag_of, flag_uf, flag_nx};

`ifdef FPU_OF_SATURATE_EN
  logic sat_to_max;

  // Round toward zero, and rounding away from the overflow direction, clamp
  // to the largest finite value. Every other mode produces Inf.
  assign sat_to_max = (RM_SI == C_RM_TRUNC) ||
                      ((RM_SI == C_RM_PLUSINF)  &&  Sign_res_DI) ||
                      ((RM_SI == C_RM_MINUSINF) && ~Sign_res_DI);

  always_comb begin
    res_next = {Sign_res_DI, Exp_res_DI, Mant_res_DI};
    if (flag_of) begin
      if (sat_to_max)
        res_next = {Sign_res_DI, {(C_EXP-1){1'b1}}, 1'b0, {C_MANT{1'b1}}};
      else
        res_next = {Sign_res_DI, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
    end
  end
`else
  logic unused_rm;

  assign unused_rm = ^RM_SI;
  assign res_next  = {Sign_res_DI, Exp_res_DI, Mant_res_DI};
`endif

  // The storage is cleared on reset so that the head outputs read zero
  // afterwards. It is therefore built from registers rather than RAM.
  generate
    for (genvar gi = 0; gi < C_DEPTH; gi++) begin : g_entry
      always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
          res_mem[gi]   <= '0;
          tag_mem[gi]   <= '0;
          flags_mem[gi] <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          res_mem[gi]   <= res_next;
          tag_mem[gi]   <= Tag_DI;
          flags_mem[gi] <= flags_next;
        end
      end
    end
  endgenerate

  // The pointers wrap naturally because C_DEPTH is a power of two.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A clear in the same cycle as a pop still keeps the popped flags.
  // This prevents the flags of that result from being lost.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI)
      fflags_reg <= '0;
    else if (Fflags_clr_SI)
      fflags_reg <= pop ? flags_mem[rd_ptr_reg] : 5'b0;
    else if (pop)
      fflags_reg <= fflags_reg | flags_mem[rd_ptr_reg];
  end

  assign Result_DO = res_mem[rd_ptr_reg];
  assign Tag_DO    = tag_mem[rd_ptr_reg];
  assign Flags_DO  = flags_mem[rd_ptr_reg];
  assign Fflags_DO = fflags_reg;

endmodule

// File: tb/tb_fpu_outbuf_fmac.sv
// ---------------------------------------------------------------------------
// tb_fpu_outbuf_fmac
// Directed self-checking bench for fpu_outbuf_fmac in its default
// configuration (C_DEPTH=2). Inputs change 1 ns after a rising edge. Outputs
// are checked in that same slot, so each check sees the state that the edge
// just produced. The expected result for overflow depends on
// FPU_OF_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_fpu_outbuf_fmac;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic [22:0] mant;
  logic [7:0]  expo;
  logic        sign;
  logic        exp_of, exp_uf, inexact, invalid, inf_in;
  logic [2:0]  rm;
  logic [3:0]  tag_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result;
  logic [3:0]  tag_out;
  logic [4:0]  flags;
  logic        fclr;
  logic [4:0]  fflags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_outbuf_fmac dut (
    .Clk_CI          (clk),
    .Rst_RI          (rst),
    .Valid_SI        (valid_in),
    .Ready_SO        (ready_out),
    .Mant_res_DI     (mant),
    .Exp_res_DI      (expo),
    .Sign_res_DI     (sign),
    .Exp_OF_SI       (exp_of),
    .Exp_UF_SI       (exp_uf),
    .Flag_Inexact_SI (inexact),
    .Flag_Invalid_SI (invalid),
    .Inf_in_SI       (inf_in),
    .RM_SI           (rm),
    .Tag_DI          (tag_in),
    .Valid_SO        (valid_out),
    .Ready_SI        (ready_in),
    .Result_DO       (result),
    .Tag_DO          (tag_out),
    .Flags_DO        (flags),
    .Fflags_clr_SI   (fclr),
    .Fflags_DO       (fflags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", name, obs, exp_v);
    end
  endtask

  // Drive a plain result with no status bits.
  task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] m, input logic [3:0] t);
    valid_in = 1'b1; sign = s; expo = e; mant = m; tag_in = t;
    exp_of = 1'b0; exp_uf = 1'b0; inexact = 1'b0; invalid = 1'b0; inf_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0; fclr = 1'b0; rm = 3'b000;
    drive(1'b0, 8'h00, 23'h0, 4'h0);
    valid_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid",  {31'b0, valid_out}, 32'h0);
    chk("rst_ready",  {31'b0, ready_out}, 32'h1);
    chk("rst_result", result, 32'h0);
    chk("rst_tag",    {28'b0, tag_out}, 32'h0);
    chk("rst_flags",  {27'b0, flags}, 32'h0);
    chk("rst_fflags", {27'b0, fflags}, 32'h0);

    // Single push of 1.0: visible one cycle later, then popped.
    ready_in = 1'b1;
    drive(1'b0, 8'h7F, 23'h0, 4'd3);
    chk("t1_no_bypass", {31'b0, valid_out}, 32'h0);
    tick();
    valid_in = 1'b0;
    $display("t1: push 1.0 tag3 -> result %h tag %0d", result, tag_out);
    chk("t1_valid",  {31'b0, valid_out}, 32'h1);
    chk("t1_result", result, 32'h3F800000);
    chk("t1_tag",    {28'b0, tag_out}, 32'd3);
    chk("t1_flags",  {27'b0, flags}, 32'h0);
    tick();
    chk("t1_empty",  {31'b0, valid_out}, 32'h0);

    // Fill with the consumer stalled. The third push must be dropped.
    ready_in = 1'b0;
    drive(1'b0, 8'h80, 23'h000000, 4'd1);   // 2.0
    tick();
    chk("t2_ready1",  {31'b0, ready_out}, 32'h1);
    chk("t2_head1",   result, 32'h40000000);
    drive(1'b0, 8'h80, 23'h400000, 4'd2);   // 3.0
    tick();
    chk("t2_full",    {31'b0, ready_out}, 32'h0);
    drive(1'b0, 8'h81, 23'h000000, 4'd5);   // 4.0, to be ignored
    tick();
    chk("t2_stillfull", {31'b0, ready_out}, 32'h0);
    chk("t2_hold",    result, 32'h40000000);
    chk("t2_holdtag", {28'b0, tag_out}, 32'd1);
    valid_in = 1'b0;
    ready_in = 1'b1;
    tick();
    $display("t2: second pop -> result %h tag %0d", result, tag_out);
    chk("t2_second",  result, 32'h40400000);
    chk("t2_secondtag", {28'b0, tag_out}, 32'd2);
    tick();
    chk("t2_dropped", {31'b0, valid_out}, 32'h0);

    // Streaming: ten results with push and pop in every cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'h7F, 23'(i + 1), 4'(i));
      tick();
      $display("t3: beat %0d -> result %h tag %0d", i, result, tag_out);
      chk("t3_valid",  {31'b0, valid_out}, 32'h1);
      chk("t3_ready",  {31'b0, ready_out}, 32'h1);
      chk("t3_result", result, {1'b0, 8'h7F, 23'(i + 1)});
      chk("t3_tag",    {28'b0, tag_out}, 32'(i));
    end
    valid_in = 1'b0;
    tick();
    chk("t3_drain", {31'b0, valid_out}, 32'h0);

    // Overflow with round-toward-zero.
    drive(1'b0, 8'hFF, 23'h0, 4'd7);
    exp_of = 1'b1;
    rm = 3'b001;
    tick();
    valid_in = 1'b0;
    $display("t4: overflow -> result %h flags %b", result, flags);
    chk("t4_flags", {27'b0, flags}, 32'b00101);
`ifdef FPU_OF_SATURATE_EN
    chk("t4_result", result, 32'h7F7FFFFF);
`else
    chk("t4_result", result, 32'h7F800000);
`endif
    tick();
    rm = 3'b000;

    // Sticky flags: start clean, accumulate NX and then NV.
    fclr = 1'b1;
    tick();
    fclr = 1'b0;
    chk("t5_cleared", {27'b0, fflags}, 32'h0);
    drive(1'b0, 8'h7F, 23'h1, 4'd1);
    inexact = 1'b1;
    tick();
    chk("t5_a_flags", {27'b0, flags}, 32'b00001);
    drive(1'b0, 8'h7F, 23'h2, 4'd2);
    invalid = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("t5_after_a", {27'b0, fflags}, 32'b00001);
    chk("t5_b_flags", {27'b0, flags}, 32'b10000);
    tick();
    $display("t5: fflags after A,B = %b", fflags);
    chk("t5_after_b", {27'b0, fflags}, 32'b10001);
    drive(1'b0, 8'h01, 23'h3, 4'd3);
    exp_uf = 1'b1; inexact = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("t5_c_flags", {27'b0, flags}, 32'b00011);
    fclr = 1'b1;
    tick();
    fclr = 1'b0;
    $display("t5: fflags after clear+pop C = %b", fflags);
    chk("t5_clr_pop", {27'b0, fflags}, 32'b00011);

    // Reset with two results buffered and the consumer stalled.
    ready_in = 1'b0;
    drive(1'b0, 8'h80, 23'h0, 4'd4);
    tick();
    drive(1'b0, 8'h80, 23'h400000, 4'd6);
    tick();
    valid_in = 1'b0;
    chk("t6_full", {31'b0, ready_out}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("t6: after reset valid %b ready %b fflags %b", valid_out, ready_out, fflags);
    chk("t6_valid",  {31'b0, valid_out}, 32'h0);
    chk("t6_ready",  {31'b0, ready_out}, 32'h1);
    chk("t6_fflags", {27'b0, fflags}, 32'h0);
    chk("t6_result", result, 32'h0);
    ready_in = 1'b1;
    drive(1'b0, 8'h82, 23'h0, 4'd9);       // 8.0
    tick();
    valid_in = 1'b0;
    chk("t6_new",    result, 32'h41000000);
    chk("t6_newtag", {28'b0, tag_out}, 32'd9);
    tick();
    chk("t6_only",   {31'b0, valid_out}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_outbuf_fmac.md
Name: fpu_outbuf_fmac

Overview:
- Output stage directly downstream of the FMAC normalization/rounding stage.
- Packs the rounded sign/exponent/mantissa and status bits into a C_OP-bit IEEE-754 word.
- Derives the per-operation exception flags and buffers results in a small FIFO with a valid/ready handshake toward the consumer (register file / core writeback).
- Accumulates a sticky fflags register across accepted results.

Parameters:
- C_OP, 32, packed result width
- C_EXP, 8, exponent width
- C_MANT, 23, stored mantissa width (hidden bit excluded)
- C_TAG, 4, width of the sideband tag carried with each result
- C_DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
- Clk_CI  in  1  clock
- Rst_RI  in  1  reset; synchronous, active-high
- Valid_SI  in  1  upstream result valid
- Ready_SO  out  1  buffer can accept (not full)
- Mant_res_DI  in  C_MANT  rounded mantissa from norm stage
- Exp_res_DI  in  C_EXP  rounded exponent from norm stage
- Sign_res_DI  in  1  result sign
- Exp_OF_SI  in  1  exponent overflow / Inf result
- Exp_UF_SI  in  1  exponent underflow / denormal result
- Flag_Inexact_SI  in  1  rounding discarded bits
- Flag_Invalid_SI  in  1  invalid operation
- Inf_in_SI  in  1  any operand infinite
- RM_SI  in  C_RM  rounding mode of this op
- Tag_DI  in  C_TAG  sideband tag
- Valid_SO  out  1  head entry valid
- Ready_SI  in  1  consumer accepts
- Result_DO  out  C_OP  packed {sign, exp, mant} of head entry
- Tag_DO  out  C_TAG  tag of head entry
- Flags_DO  out  5  per-op flags of head entry {NV,DZ,OF,UF,NX}
- Fflags_clr_SI  in  1  clear accumulated flags
- Fflags_DO  out  5  accumulated sticky flags, same order

Behaviour:
- Push = Valid_SI & Ready_SO. Pop = Valid_SO & Ready_SI.
- Ready_SO = (count != C_DEPTH), driven from registered count only; no combinational path from Ready_SI to Ready_SO.
- Latency: entry pushed in cycle N appears on outputs in cycle N+1 at the earliest. No bypass.
- FIFO uses read/write pointers of log2(C_DEPTH) bits that wrap modulo C_DEPTH, plus a count of log2(C_DEPTH)+1 bits.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Push while empty with pop asserted: pop is ignored (Valid_SO=0).
- Full: Ready_SO=0; Valid_SI is ignored.
- Outputs hold stable while Valid_SO & ~Ready_SI.
- Packing: Result = {Sign_res_DI, Exp_res_DI, Mant_res_DI}, computed at push and stored.
- Per-op flags, computed at push:
  - NV = Flag_Invalid_SI
  - DZ = 0
  - OF = Exp_OF_SI & ~Flag_Invalid_SI & ~Inf_in_SI
  - UF = Exp_UF_SI & Flag_Inexact_SI & ~Flag_Invalid_SI
  - NX = (Flag_Inexact_SI | OF) & ~Flag_Invalid_SI
- Fflags register, each cycle:
  - Clear only: Fflags <= 0.
  - Clear and pop in the same cycle: Fflags <= popped entry's Flags.
  - Pop only: Fflags <= Fflags | popped entry's Flags.
- Reset (in any state, including mid-transfer): count=0, pointers=0, Valid_SO=0, Ready_SO=1 from the next cycle, Result_DO=0, Tag_DO=0, Flags_DO=0, Fflags_DO=0. Buffered entries are discarded.
- Outputs with Valid_SO=0 show the storage at the read pointer. Consumers must qualify them with Valid_SO.

Optional Feature:
- Macro FPU_OF_SATURATE_EN.
- Defined: when OF=1 (computed as above), the packed result is replaced by the IEEE overflow result:
  - RM=C_RM_TRUNC: largest finite, exp=2^C_EXP-2, mant all ones.
  - RM=C_RM_PLUSINF with sign=1: largest finite.
  - RM=C_RM_MINUSINF with sign=0: largest finite.
  - Otherwise: Inf, exp all ones, mant 0.
  - Sign is preserved in all cases.
- Not defined: Result is always the plain pack. The RM_SI port exists but is unused.

Test Plan:
- Push sign=0, exp=0x7F, mant=0, flags 0, tag=3 with Ready_SI=1 → next cycle Valid_SO=1, Result_DO=0x3F800000, Tag_DO=3, Flags_DO=0; following cycle Valid_SO=0.
- Hold Ready_SI=0 and push 3 results (C_DEPTH=2) → Ready_SO=0 after the 2nd push, 3rd ignored. Release Ready_SI → results pop in order 1, 2, then Valid_SO=0.
- Back-to-back push/pop stream of 10 results with Ready_SI=1 → Ready_SO stays 1, all 10 appear in order with 1-cycle latency, pointer wrap correct.
- Exp_OF_SI=1, Inf_in_SI=0, Flag_Invalid_SI=0, sign=0, exp=0xFF, mant=0, RM=C_RM_TRUNC → Flags_DO=5'b00101. Result_DO=0x7F7FFFFF with FPU_OF_SATURATE_EN, 0x7F800000 without.
- Pop op A with NX (5'b00001), then op B with NV (5'b10000) → Fflags_DO=5'b10001. Assert Fflags_clr_SI in the same cycle as popping op C with UF|NX (5'b00011) → Fflags_DO=5'b00011.
- Assert Rst_RI with 2 entries buffered and Ready_SI=0 → next cycle Valid_SO=0, Ready_SO=1, Fflags_DO=0. A subsequent push returns only the new result.
